wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline writeback stage and a long-latency execution unit (mul/div). Sits between WB and the register file. Holds up to DEPTH unit results in a small queue. Guarantees one write per cycle, same-register write ordering, and bounded starvation of the unit. The zero register is never written.

---
 rtl/wb_port_arbiter_if.sv | 29 ++
 rtl/wb_port_arbiter.sv | 100 ++++++++++
 tb/tb_wb_port_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the WB stage / mul-div unit and the register-file write arbiter.
interface wb_port_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          wb_valid;
    logic [AW-1:0] wb_idx;
    logic [DW-1:0] wb_data;
    logic          wb_stall;
    logic          mu_valid;
    logic [AW-1:0] mu_idx;
    logic [DW-1:0] mu_data;
    logic          mu_ready;
    logic          reg_we;
    logic [AW-1:0] reg_idx;
    logic [DW-1:0] reg_data;
    logic          grant_src;
    logic          busy;

    modport slave (
        input  wb_valid, wb_idx, wb_data, mu_valid, mu_idx, mu_data,
        output wb_stall, mu_ready, reg_we, reg_idx, reg_data, grant_src, busy
    );

    modport master (
        output wb_valid, wb_idx, wb_data, mu_valid, mu_idx, mu_data,
        input  wb_stall, mu_ready, reg_we, reg_idx, reg_data, grant_src, busy
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: WB stage vs. a queued long-latency unit,
// with same-register ordering and bounded starvation of the unit queue.
module wb_port_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = 4;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          mu_ready_q, busy_q, reg_we_q, grant_src_q;
    logic [AW-1:0] reg_idx_q;
    logic [DW-1:0] reg_data_q;

    logic have, gnt_head, gnt_wb, enq;
    ent_t head;

    assign have = (cnt_q != '0);
    assign head = mem_q[rd_ptr_q];
    assign enq  = bus.mu_valid & mu_ready_q;

    // The head wins whenever WB is idle, WB targets the same register
    // (older result must land first), or WB has starved it long enough.
    assign gnt_head = have & (~bus.wb_valid
                              | (bus.wb_idx == head.idx)
                              | (starve_q == SW'(STARVE_MAX)));
    assign gnt_wb   = bus.wb_valid & ~gnt_head;
    assign bus.wb_stall = bus.wb_valid & gnt_head;

    assign cnt_d = cnt_q + CW'(enq) - CW'(gnt_head);

    always_comb begin
        starve_d = '0;
        if (have && !gnt_head)
            starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (enq)
            mem_q[wr_ptr_q] <= '{idx: bus.mu_idx, data: bus.mu_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            starve_q    <= '0;
            mu_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_idx_q   <= '0;
            reg_data_q  <= '0;
            grant_src_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            mu_ready_q <= (cnt_d != CW'(DEPTH));
            busy_q     <= (cnt_d != '0);
            if (enq)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (gnt_head) begin
                rd_ptr_q    <= rd_ptr_q + PW'(1);
                reg_we_q    <= (head.idx != '0);
                reg_idx_q   <= head.idx;
                reg_data_q  <= head.data;
                grant_src_q <= 1'b1;
            end else if (gnt_wb) begin
                reg_we_q    <= (bus.wb_idx != '0);
                reg_idx_q   <= bus.wb_idx;
                reg_data_q  <= bus.wb_data;
                grant_src_q <= 1'b0;
            end else begin
                reg_we_q    <= 1'b0;
            end
        end
    end

    assign bus.mu_ready  = mu_ready_q;
    assign bus.busy      = busy_q;
    assign bus.reg_we    = reg_we_q;
    assign bus.reg_idx   = reg_idx_q;
    assign bus.reg_data  = reg_data_q;
    assign bus.grant_src = grant_src_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, async-reset sequence and
// random traffic against a queue-based reference model.
module tb_wb_port_arbiter;
    localparam int DW = 32, AW = 5, DEPTH = 2, SMAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DW(DW), .AW(AW)) bus ();
    wb_port_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .STARVE_MAX(SMAX))
        dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct {
        logic wv; logic [AW-1:0] wi; logic [DW-1:0] wd;
        logic mv; logic [AW-1:0] mi; logic [DW-1:0] md;
        logic st; logic we; logic [AW-1:0] ri; logic [DW-1:0] rd;
        logic src; logic busy; logic rdy;
    } vec_t;

    // reference model state
    ent_t          mq[$];
    int            starve;
    logic          m_we, m_src, m_busy, m_rdy, m_stall;
    logic [AW-1:0] m_idx;
    logic [DW-1:0] m_data;
    logic          dut_stall;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        starve = 0;
        m_we = 0; m_idx = '0; m_data = '0; m_src = 0; m_busy = 0; m_rdy = 1;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".we"}, 64'(bus.reg_we), 64'(m_we));
        if (m_we) begin
            chk({tag, ".idx"}, 64'(bus.reg_idx), 64'(m_idx));
            chk({tag, ".data"}, 64'(bus.reg_data), 64'(m_data));
        end
        chk({tag, ".src"}, 64'(bus.grant_src), 64'(m_src));
        chk({tag, ".busy"}, 64'(bus.busy), 64'(m_busy));
        chk({tag, ".rdy"}, 64'(bus.mu_ready), 64'(m_rdy));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".we"}, 64'(bus.reg_we), 64'(0));
        chk({tag, ".idx"}, 64'(bus.reg_idx), 64'(0));
        chk({tag, ".data"}, 64'(bus.reg_data), 64'(0));
        chk({tag, ".src"}, 64'(bus.grant_src), 64'(0));
        chk({tag, ".busy"}, 64'(bus.busy), 64'(0));
        chk({tag, ".rdy"}, 64'(bus.mu_ready), 64'(1));
    endtask

    // One clock: drive, check the combinational stall, advance, check outputs.
    task automatic cycle(input logic wv, input logic [AW-1:0] wi, input logic [DW-1:0] wd,
                         input logic mv, input logic [AW-1:0] mi, input logic [DW-1:0] md,
                         input string tag);
        logic have, gh, gw, enq;
        ent_t h;
        bus.wb_valid = wv; bus.wb_idx = wi; bus.wb_data = wd;
        bus.mu_valid = mv; bus.mu_idx = mi; bus.mu_data = md;
        #1;
        have = (mq.size() > 0);
        gh = 0;
        h = '{idx: '0, data: '0};
        if (have) begin
            h  = mq[0];
            gh = !wv || (wi == h.idx) || (starve == SMAX);
        end
        gw = wv && !gh;
        m_stall = wv && gh;
        enq = mv && m_rdy;
        dut_stall = bus.wb_stall;
        chk({tag, ".stall"}, 64'(dut_stall), 64'(m_stall));
        @(posedge clk);
        if (gh) begin
            m_we = (h.idx != 0); m_idx = h.idx; m_data = h.data; m_src = 1;
            void'(mq.pop_front());
            starve = 0;
        end else if (gw) begin
            m_we = (wi != 0); m_idx = wi; m_data = wd; m_src = 0;
            starve = have ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
        end else begin
            m_we = 0;
            starve = 0;
        end
        if (enq) mq.push_back('{idx: mi, data: md});
        m_busy = (mq.size() != 0);
        m_rdy  = (mq.size() != DEPTH);
        #1;
        chk_regs(tag);
    endtask

    vec_t vt[23];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          hold, wv, mv;
        logic [AW-1:0] wi, mi;
        logic [DW-1:0] wd, md;

        //          wv wi  wd      mv mi  md        st we ri  rd        src busy rdy
        vt[0]  = '{1, 3,  'h11,   0, 0,  0,        0, 1, 3,  'h11,     0, 0, 1};
        vt[1]  = '{0, 0,  0,      0, 0,  0,        0, 0, 0,  0,        0, 0, 1};
        vt[2]  = '{0, 0,  0,      1, 7,  'hABCD,   0, 0, 0,  0,        0, 1, 1};
        vt[3]  = '{0, 0,  0,      0, 0,  0,        0, 1, 7,  'hABCD,   1, 0, 1};
        vt[4]  = '{0, 0,  0,      0, 0,  0,        0, 0, 0,  0,        1, 0, 1};
        vt[5]  = '{0, 0,  0,      1, 9,  'h99,     0, 0, 0,  0,        1, 1, 1};
        vt[6]  = '{1, 1,  'h101,  0, 0,  0,        0, 1, 1,  'h101,    0, 1, 1};
        vt[7]  = '{1, 2,  'h102,  0, 0,  0,        0, 1, 2,  'h102,    0, 1, 1};
        vt[8]  = '{1, 3,  'h103,  0, 0,  0,        0, 1, 3,  'h103,    0, 1, 1};
        vt[9]  = '{1, 4,  'h104,  0, 0,  0,        0, 1, 4,  'h104,    0, 1, 1};
        vt[10] = '{1, 5,  'h105,  0, 0,  0,        1, 1, 9,  'h99,     1, 0, 1};
        vt[11] = '{1, 5,  'h105,  0, 0,  0,        0, 1, 5,  'h105,    0, 0, 1};
        vt[12] = '{0, 0,  0,      1, 4,  'h44,     0, 0, 0,  0,        0, 1, 1};
        vt[13] = '{1, 4,  'h55,   0, 0,  0,        1, 1, 4,  'h44,     1, 0, 1};
        vt[14] = '{1, 4,  'h55,   0, 0,  0,        0, 1, 4,  'h55,     0, 0, 1};
        vt[15] = '{1, 1,  'h201,  1, 0,  'hE0,     0, 1, 1,  'h201,    0, 1, 1};
        vt[16] = '{1, 2,  'h202,  1, 6,  'hE6,     0, 1, 2,  'h202,    0, 1, 0};
        vt[17] = '{1, 3,  'h203,  1, 8,  'hE8,     0, 1, 3,  'h203,    0, 1, 0};
        vt[18] = '{0, 0,  0,      1, 8,  'hE8,     0, 0, 0,  0,        1, 1, 1};
        vt[19] = '{0, 0,  0,      1, 8,  'hE8,     0, 1, 6,  'hE6,     1, 1, 1};
        vt[20] = '{0, 0,  0,      0, 0,  0,        0, 1, 8,  'hE8,     1, 0, 1};
        vt[21] = '{0, 0,  0,      0, 0,  0,        0, 0, 0,  0,        1, 0, 1};
        vt[22] = '{1, 0,  'h77,   0, 0,  0,        0, 0, 0,  0,        0, 0, 1};

        bus.wb_valid = 0; bus.wb_idx = '0; bus.wb_data = '0;
        bus.mu_valid = 0; bus.mu_idx = '0; bus.mu_data = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        chk("reset.stall", 64'(bus.wb_stall), 64'(0));
        @(negedge clk);
        rst = 1;

        for (int i = 0; i < 23; i++) begin
            string t;
            t = $sformatf("v%0d", i);
            cycle(vt[i].wv, vt[i].wi, vt[i].wd, vt[i].mv, vt[i].mi, vt[i].md, t);
            chk({t, ".tstall"}, 64'(dut_stall), 64'(vt[i].st));
            chk({t, ".twe"}, 64'(bus.reg_we), 64'(vt[i].we));
            if (vt[i].we) begin
                chk({t, ".tidx"}, 64'(bus.reg_idx), 64'(vt[i].ri));
                chk({t, ".tdata"}, 64'(bus.reg_data), 64'(vt[i].rd));
            end
            chk({t, ".tsrc"}, 64'(bus.grant_src), 64'(vt[i].src));
            chk({t, ".tbusy"}, 64'(bus.busy), 64'(vt[i].busy));
            chk({t, ".trdy"}, 64'(bus.mu_ready), 64'(vt[i].rdy));
        end

        // two entries queued, starve count at 3, then reset between edges
        cycle(1, 1, 'h301, 1, 10, 'hA0, "ar0");
        cycle(1, 2, 'h302, 1, 11, 'hA1, "ar1");
        cycle(1, 3, 'h303, 0, 0, 0, "ar2");
        cycle(1, 4, 'h304, 0, 0, 0, "ar3");
        chk("ar.model_starve", 64'(starve), 64'(3));
        chk("ar.full", 64'(bus.mu_ready), 64'(0));
        bus.wb_valid = 1; bus.wb_idx = 5; bus.wb_data = 'h305;
        bus.mu_valid = 0;
        #2;
        rst = 0;
        #1;
        chk_reset_vals("async");
        chk("async.stall", 64'(bus.wb_stall), 64'(0));
        @(negedge clk);
        rst = 1;
        m_reset();
        for (int i = 0; i < 3; i++)
            cycle(0, 0, 0, 0, 0, 0, $sformatf("post%0d", i));

        hold = 0;
        wv = 0; wi = '0; wd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!hold) begin
                wv = ($urandom_range(0, 3) != 0);
                wi = AW'($urandom_range(0, 7));
                wd = $urandom;
            end
            mv = ($urandom_range(0, 1) != 0);
            mi = AW'($urandom_range(0, 7));
            md = $urandom;
            cycle(wv, wi, wd, mv, mi, md, $sformatf("r%0d", i));
            hold = m_stall;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
